// File: rtl/elastic_async_operator.sv
// Handshaked dataflow operator: one token per input, selectable op, results buffered in a FIFO and forked to OUTPUT_SIZE consumers.
// Optional EOP_STATS_EN adds saturating fire_count / stall_count outputs.
module elastic_async_operator #(
  parameter int                    DATA_WIDTH  = 32,
  parameter string                 OP          = "reg",
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0,
  parameter int                    INPUT_SIZE  = 1,
  parameter int                    OUTPUT_SIZE = 1,
  parameter int                    DEPTH       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [INPUT_SIZE-1:0]            req_l,
  input  logic [INPUT_SIZE-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
  input  logic [OUTPUT_SIZE-1:0]           req_r,
  output logic [OUTPUT_SIZE-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]            dout
`ifdef EOP_STATS_EN
  ,
  output logic [31:0]                      fire_count,
  output logic [31:0]                      stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0]  din_r [INPUT_SIZE];
  logic [INPUT_SIZE-1:0]  has;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count;
  logic [OUTPUT_SIZE-1:0] served, issue;
  logic                   full, pop, fire;
  logic [DATA_WIDTH-1:0]  result;

  always_comb begin
    full  = (count == CW'(DEPTH));
    issue = req_r & ~served & ~ack_r & {OUTPUT_SIZE{count != '0}};
    pop   = (count != '0) && (&(served | issue));
    fire  = (&has) && (!full || pop);
  end

  always_comb begin
    result = din_r[0];
    if (OP == "addi")      result = din_r[0] + IMMEDIATE;
    else if (OP == "subi") result = din_r[0] - IMMEDIATE;
    else if (OP == "muli") result = din_r[0] * IMMEDIATE;
    else begin
      for (int k = 1; k < INPUT_SIZE; k++) begin
        if (OP == "add")      result = result + din_r[k];
        else if (OP == "sub") result = result - din_r[k];
        else if (OP == "mul") result = result * din_r[k];
        else if (OP == "min") begin
          if (din_r[k] < result) result = din_r[k];
        end else if (OP == "max") begin
          if (din_r[k] > result) result = din_r[k];
        end
      end
    end
  end

  // A second ack while a token is already held is dropped without touching state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      has   <= '0;
      req_l <= '0;
      for (int i = 0; i < INPUT_SIZE; i++) din_r[i] <= '0;
    end else begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        if (ack_l[i] && !has[i]) begin
          din_r[i] <= din[DATA_WIDTH*i +: DATA_WIDTH];
          has[i]   <= 1'b1;
          req_l[i] <= 1'b0;
        end else if (fire) begin
          has[i] <= 1'b0;
        end else if (!has[i] && !req_l[i] && !ack_l[i]) begin
          req_l[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fire) wr_ptr <= wr_ptr + 1'b1;
      if (fire && !pop)      count <= count + 1'b1;
      else if (!fire && pop) count <= count - 1'b1;
    end
  end

  // Every ack of one edge carries the same head entry; the head retires once all consumers took it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r  <= '0;
      served <= '0;
      dout   <= '0;
      rd_ptr <= '0;
    end else begin
      ack_r <= issue;
      if (|issue) dout <= mem[rd_ptr];
      if (pop) begin
        served <= '0;
        rd_ptr <= rd_ptr + 1'b1;
      end else begin
        served <= served | issue;
      end
    end
  end

`ifdef EOP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_count  <= '0;
      stall_count <= '0;
    end else begin
      if (fire && fire_count != '1) fire_count <= fire_count + 1'b1;
      if ((&has) && full && !pop && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_elastic_async_operator.sv
// Self-checking bench: a 3-input "sub" operator with two consumers and a 1-input "addi" operator,
// each checked against a queue-based model of the token stream.
module tb_elastic_async_operator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- main DUT: sub, 3 inputs, 2 consumers, depth 4
  logic [2:0]  m_req_l, m_ack_l;
  logic [95:0] m_din;
  logic [1:0]  m_req_r, m_ack_r;
  logic [31:0] m_dout;
`ifdef EOP_STATS_EN
  logic [31:0] m_fire_count, m_stall_count;
  logic [31:0] a_fire_count, a_stall_count;
`endif

  elastic_async_operator #(
    .DATA_WIDTH(32), .OP("sub"), .IMMEDIATE(32'd0),
    .INPUT_SIZE(3), .OUTPUT_SIZE(2), .DEPTH(4)
  ) u_main (
    .clk(clk), .rst(rst),
    .req_l(m_req_l), .ack_l(m_ack_l), .din(m_din),
    .req_r(m_req_r), .ack_r(m_ack_r), .dout(m_dout)
`ifdef EOP_STATS_EN
    , .fire_count(m_fire_count), .stall_count(m_stall_count)
`endif
  );

  // ---------------- second DUT: addi 2, 1 input, 1 consumer, depth 2
  logic        a_req_l, a_ack_l, a_req_r, a_ack_r;
  logic [31:0] a_din, a_dout;

  elastic_async_operator #(
    .DATA_WIDTH(32), .OP("addi"), .IMMEDIATE(32'd2),
    .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(2)
  ) u_addi (
    .clk(clk), .rst(rst),
    .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din),
    .req_r(a_req_r), .ack_r(a_ack_r), .dout(a_dout)
`ifdef EOP_STATS_EN
    , .fire_count(a_fire_count), .stall_count(a_stall_count)
`endif
  );

  // ---------------- model state
  logic [31:0] q0[$], q1[$], q2[$];
  logic [31:0] exp_q[$];
  int          idx[2];
  logic [31:0] last_dout[2];
  logic [1:0]  prev_req;
  int          prod_left[3];
  int          prod_rate;
  bit          fixed_en;
  logic [31:0] fixed_val[3];
  bit          err_pulse;
  int          cons_mode[2];

  logic [31:0] a_exp[$];
  int          a_got = 0;
  int          a_t_ack = 0;
  int          a_first_ack = 0;
  logic [31:0] a_first_val = '0;

  task automatic clear_model();
    q0.delete(); q1.delete(); q2.delete(); exp_q.delete();
    idx = '{0, 0};
    last_dout = '{32'd0, 32'd0};
    prev_req = '0;
  endtask

  // Producers and consumers of the main DUT; acks only when a request is visible, so each is accepted.
  initial begin
    logic [31:0] v;
    m_ack_l = '0; m_din = '0; m_req_r = '0;
    forever begin
      @(posedge clk); #1;
      m_ack_l = '0;
      if (!rst) begin
        for (int i = 0; i < 3; i++) begin
          if (m_req_l[i] && prod_left[i] > 0 && $urandom_range(0, 99) < prod_rate) begin
            v = fixed_en ? fixed_val[i] : $urandom;
            m_ack_l[i] = 1'b1;
            m_din[32*i +: 32] = v;
            prod_left[i]--;
            if (i == 0) q0.push_back(v);
            else if (i == 1) q1.push_back(v);
            else q2.push_back(v);
          end
        end
        if (err_pulse) begin
          m_ack_l[0] = 1'b1;
          m_din[31:0] = 32'hDEAD_BEEF;
          err_pulse = 1'b0;
        end
        while (q0.size() > 0 && q1.size() > 0 && q2.size() > 0)
          exp_q.push_back(q0.pop_front() - q1.pop_front() - q2.pop_front());
        for (int j = 0; j < 2; j++)
          m_req_r[j] = (cons_mode[j] == 1) ? 1'b1 :
                       (cons_mode[j] == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Compare process for the main DUT: every ack must answer a request and deliver the next result in order.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int j = 0; j < 2; j++) begin
          if (m_ack_r[j]) begin
            check($sformatf("ack_req_c%0d", j), 32'(prev_req[j]), 32'd1);
            if (idx[j] < exp_q.size())
              check($sformatf("dout_c%0d_n%0d", j, idx[j]), m_dout, exp_q[idx[j]]);
            else
              check($sformatf("extra_result_c%0d", j), idx[j], exp_q.size());
            last_dout[j] = m_dout;
            idx[j]++;
          end
        end
        prev_req = m_req_r;
      end
    end
  end

  // Compare process for the addi DUT.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && a_ack_r) begin
        if (a_got == 0) begin
          a_first_ack = cyc;
          a_first_val = a_dout;
        end
        if (a_got < a_exp.size()) check($sformatf("addi_dout_n%0d", a_got), a_dout, a_exp[a_got]);
        else check("addi_extra", a_got, a_exp.size());
        a_got++;
      end
    end
  end

  task automatic wait_got(input int t0, input int t1, input int limit, input string name);
    int c = 0;
    while ((idx[0] < t0 || idx[1] < t1) && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({name, "_c0"}, idx[0], t0);
    check({name, "_c1"}, idx[1], t1);
  endtask

  task automatic addi_stream(input int n, input bit rnd, input int budget);
    logic [31:0] v;
    int sent = 0;
    int base = a_got;
    int c = 0;
    while ((sent < n || a_got < base + n) && c < budget) begin
      @(posedge clk); #1;
      c++;
      a_ack_l = 1'b0;
      a_req_r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (a_req_l && sent < n && (!rnd || $urandom_range(0, 1) == 1)) begin
        v = rnd ? $urandom : 32'(sent);
        a_ack_l = 1'b1;
        a_din = v;
        a_exp.push_back(v + 32'd2);
        if (a_exp.size() == 1) a_t_ack = cyc;
        sent++;
      end
    end
    @(posedge clk); #1;
    a_ack_l = 1'b0;
    a_req_r = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("addi_count", a_got - base, n);
  endtask

  initial begin
    int b0, b1, c;
`ifdef EOP_STATS_EN
    logic [31:0] s1;
`endif
    a_ack_l = 1'b0; a_din = '0; a_req_r = 1'b0;
    prod_left = '{0, 0, 0};
    prod_rate = 100;
    fixed_en = 1'b0;
    fixed_val = '{32'd0, 32'd0, 32'd0};
    err_pulse = 1'b0;
    cons_mode = '{0, 0};
    clear_model();

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_l", 32'(m_req_l), 32'd0);
    check("rst_ack_r", 32'(m_ack_r), 32'd0);
    check("rst_dout", m_dout, 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("req_l_rise", 32'(m_req_l), 32'h7);

    // addi: values 0..9 with a steady consumer, then a long randomized run
    addi_stream(10, 1'b0, 200);
    check("addi_latency", a_first_ack - a_t_ack, 3);
    check("addi_first_val", a_first_val, 32'd2);
    check("addi_model_pin", a_exp[9], 32'd11);
    addi_stream(1000, 1'b1, 20000);
`ifdef EOP_STATS_EN
    check("addi_fire_count", a_fire_count, 32'd1010);
`endif

    // sub with literal operands, including wrap-around
    cons_mode = '{1, 1};
    fixed_en = 1'b1;
    fixed_val = '{32'd10, 32'd3, 32'd2};
    prod_left = '{1, 1, 1};
    wait_got(1, 1, 60, "sub_a");
    check("sub_a_model", exp_q[0], 32'd5);
    check("sub_a_dout", last_dout[0], 32'd5);
    fixed_val = '{32'd0, 32'd1, 32'd0};
    prod_left = '{1, 1, 1};
    wait_got(2, 2, 60, "sub_b");
    check("sub_b_dout", last_dout[1], 32'hFFFF_FFFF);
    fixed_en = 1'b0;

    // consumer 1 stalled: head cannot retire, FIFO fills, operands back up
    b0 = idx[0]; b1 = idx[1];
    cons_mode = '{1, 0};
    prod_left = '{6, 6, 6};
    repeat (60) @(posedge clk);
    #1;
    check("stall_c0_got", idx[0] - b0, 1);
    check("stall_c1_got", idx[1] - b1, 0);
    check("stall_req_l", 32'(m_req_l), 32'd0);
    check("stall_left", prod_left[0] + prod_left[1] + prod_left[2], 3);
`ifdef EOP_STATS_EN
    s1 = m_stall_count;
    repeat (5) @(posedge clk);
    #1;
    check("stall_count_grows", m_stall_count - s1, 32'd5);
`endif
    cons_mode = '{1, 1};
    wait_got(b0 + 6, b1 + 6, 300, "stall_release");

    // second ack on a held input is discarded
    b0 = idx[0]; b1 = idx[1];
    fixed_en = 1'b1;
    fixed_val = '{32'd100, 32'd30, 32'd20};
    prod_left = '{1, 0, 0};
    c = 0;
    while (q0.size() == 0 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    err_pulse = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    prod_left = '{0, 1, 1};
    wait_got(b0 + 1, b1 + 1, 60, "dbl_ack");
    check("dbl_ack_dout", last_dout[0], 32'd50);
    fixed_en = 1'b0;

    // randomized traffic on both sides
    b0 = idx[0]; b1 = idx[1];
    prod_rate = 60;
    cons_mode = '{2, 2};
    prod_left = '{200, 200, 200};
    wait_got(b0 + 200, b1 + 200, 20000, "random");
`ifdef EOP_STATS_EN
    check("main_fire_count", m_fire_count, exp_q.size());
`endif

    // asynchronous reset with results parked in the FIFO
    prod_rate = 100;
    cons_mode = '{0, 0};
    prod_left = '{3, 3, 3};
    repeat (30) @(posedge clk);
    check("parked_results", exp_q.size() - idx[0], 3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_req_l", 32'(m_req_l), 32'd0);
    check("arst_ack_r", 32'(m_ack_r), 32'd0);
    check("arst_dout", m_dout, 32'd0);
    prod_left = '{0, 0, 0};
    clear_model();
    cons_mode = '{1, 1};
    @(posedge clk);
    #4 rst = 1'b0;
    fixed_en = 1'b1;
    fixed_val = '{32'd7, 32'd2, 32'd1};
    prod_left = '{1, 1, 1};
    wait_got(1, 1, 60, "post_rst");
    check("post_rst_dout", last_dout[0], 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
